// File: rtl/otter_pkg.sv
// Shared types for the OTTER writeback stage: write-select encoding, load funct3 codes, buffer entry.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package otter_pkg;

   typedef enum logic [1:0] {
      SEL_PC4 = 2'd0,
      SEL_CSR = 2'd1,
      SEL_MEM = 2'd2,
      SEL_ALU = 2'd3
   } rf_wr_sel_t;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;

   // One buffered register-file write; wflag=0 entries still retire but never write.
   typedef struct packed {
      logic        wflag;
      logic [4:0]  rd;
      logic [31:0] data;
   } wb_entry_t;

endpackage

// File: rtl/wb_load_align.sv
// Extracts and extends the addressed byte/half/word from a word-aligned memory read.
// Latency: purely combinational.
// Backpressure: none.
module wb_load_align
   import otter_pkg::*;
(
   input  logic [31:0] word,
   input  logic [1:0]  addr,
   input  logic [2:0]  funct3,
   output logic [31:0] data
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   // Lane select then extend; misaligned halves/words just use the lane bits, no trap.
   always_comb begin
      byte_sel = word[{addr, 3'b000} +: 8];
      half_sel = addr[1] ? word[31:16] : word[15:0];
      case (funct3)
         F3_LB:   data = {{24{byte_sel[7]}}, byte_sel};
         F3_LH:   data = {{16{half_sel[15]}}, half_sel};
         F3_LW:   data = word;
         F3_LBU:  data = {24'h000000, byte_sel};
         F3_LHU:  data = {16'h0000, half_sel};
         default: data = word;
      endcase
   end

endmodule

// File: rtl/writeback_stage.sv
// Final pipeline stage: picks the rd write value, buffers DEPTH results, drains them to the register file.
// Latency: 1 cycle from accept to the entry appearing on the register-file write port.
// Backpressure: WB_IN_READY drops when the buffer is full (registered, independent of RF_READY).
module writeback_stage
   import otter_pkg::*;
#(
   parameter int DEPTH = 2,
   parameter int CNT_W = 64
) (
   input  logic             WB_CLOCK,
   input  logic             WB_RESET_N,
   input  logic             MEM_REG_VALID,
   output logic             WB_IN_READY,
   input  logic [31:0]      MEM_REG_IR,
   input  logic [31:0]      MEM_REG_PC_4,
   input  logic [31:0]      MEM_REG_ALU_RESULT,
   input  logic [31:0]      MEM_REG_DOUT2,
   input  logic [1:0]       MEM_RF_WR_SEL,
   input  logic             MEM_REG_WRITE,
   input  logic [31:0]      CSR_RD,
   input  logic             RF_READY,
   output logic             WB_RF_WE,
   output logic [4:0]       WB_RF_WA,
   output logic [31:0]      WB_RF_WD,
   input  logic [4:0]       WB_FWD_ADDR,
   output logic             WB_FWD_HIT,
   output logic [31:0]      WB_FWD_DATA,
   output logic [CNT_W-1:0] WB_INSTRET
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   wb_entry_t     fifo_mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [CW-1:0] count;

   logic          full;
   logic          head_valid;
   logic          enq;
   logic          deq;
   rf_wr_sel_t    sel;
   logic [31:0]   load_data;
   logic [31:0]   wr_value;
   wb_entry_t     new_entry;
   wb_entry_t     head_entry;
   logic [AW-1:0] fwd_idx;

   assign sel        = rf_wr_sel_t'(MEM_RF_WR_SEL);
   assign full       = (count == CW'(DEPTH));
   assign head_valid = (count != '0);
   assign enq        = MEM_REG_VALID && !full;
   assign deq        = head_valid && RF_READY;

   assign WB_IN_READY = !full;

   wb_load_align u_load_align (
      .word   (MEM_REG_DOUT2),
      .addr   (MEM_REG_ALU_RESULT[1:0]),
      .funct3 (MEM_REG_IR[14:12]),
      .data   (load_data)
   );

   // Register-file write value chosen by the write-select field.
   always_comb begin
      case (sel)
         SEL_PC4: wr_value = MEM_REG_PC_4;
         SEL_CSR: wr_value = CSR_RD;
         SEL_MEM: wr_value = load_data;
         default: wr_value = MEM_REG_ALU_RESULT;
      endcase
   end

   assign new_entry.wflag = MEM_REG_WRITE && (MEM_REG_IR[11:7] != 5'd0);
   assign new_entry.rd    = MEM_REG_IR[11:7];
   assign new_entry.data  = wr_value;

   // Storage array needs no reset: every read is gated by the occupancy count.
   always_ff @(posedge WB_CLOCK) begin
      if (enq) begin
         fifo_mem[wr_ptr] <= new_entry;
      end
   end

   // Pointers, occupancy and retire counter; reset discards anything in flight.
   always_ff @(posedge WB_CLOCK or negedge WB_RESET_N) begin
      if (!WB_RESET_N) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
         WB_INSTRET <= '0;
      end else begin
         if (enq) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (deq) begin
            rd_ptr     <= rd_ptr + AW'(1);
            WB_INSTRET <= WB_INSTRET + CNT_W'(1);
         end
         case ({enq, deq})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   assign head_entry = fifo_mem[rd_ptr];
   assign WB_RF_WE   = head_valid && head_entry.wflag;
   assign WB_RF_WA   = head_valid ? head_entry.rd   : 5'd0;
   assign WB_RF_WD   = head_valid ? head_entry.data : 32'd0;

   // Forwarding search oldest to youngest so the youngest matching write overrides.
   always_comb begin
      WB_FWD_HIT  = 1'b0;
      WB_FWD_DATA = 32'd0;
      fwd_idx     = rd_ptr;
      for (int k = 0; k < DEPTH; k++) begin
         fwd_idx = rd_ptr + AW'(k);
         if ((CW'(k) < count) && fifo_mem[fwd_idx].wflag &&
             (fifo_mem[fwd_idx].rd == WB_FWD_ADDR) && (WB_FWD_ADDR != 5'd0)) begin
            WB_FWD_HIT  = 1'b1;
            WB_FWD_DATA = fifo_mem[fwd_idx].data;
         end
      end
   end

endmodule

// File: tb/tb_writeback_stage.sv
// Directed bench for writeback_stage with a write scoreboard.
// Latency: n/a (testbench).
// Backpressure: RF_READY driven by the stimulus sequence.
module tb_writeback_stage;

   logic        clk;
   logic        rst_n;
   logic        mem_valid;
   logic        in_ready;
   logic [31:0] mem_ir;
   logic [31:0] mem_pc4;
   logic [31:0] mem_alu;
   logic [31:0] mem_dout2;
   logic [1:0]  mem_sel;
   logic        mem_regw;
   logic [31:0] csr_rd;
   logic        rf_ready;
   logic        rf_we;
   logic [4:0]  rf_wa;
   logic [31:0] rf_wd;
   logic [4:0]  fwd_addr;
   logic        fwd_hit;
   logic [31:0] fwd_data;
   logic [63:0] instret;

   int compared = 0;
   int mismatched = 0;

   logic [36:0] sb [$];

   writeback_stage #(.DEPTH(2), .CNT_W(64)) dut (
      .WB_CLOCK           (clk),
      .WB_RESET_N         (rst_n),
      .MEM_REG_VALID      (mem_valid),
      .WB_IN_READY        (in_ready),
      .MEM_REG_IR         (mem_ir),
      .MEM_REG_PC_4       (mem_pc4),
      .MEM_REG_ALU_RESULT (mem_alu),
      .MEM_REG_DOUT2      (mem_dout2),
      .MEM_RF_WR_SEL      (mem_sel),
      .MEM_REG_WRITE      (mem_regw),
      .CSR_RD             (csr_rd),
      .RF_READY           (rf_ready),
      .WB_RF_WE           (rf_we),
      .WB_RF_WA           (rf_wa),
      .WB_RF_WD           (rf_wd),
      .WB_FWD_ADDR        (fwd_addr),
      .WB_FWD_HIT         (fwd_hit),
      .WB_FWD_DATA        (fwd_data),
      .WB_INSTRET         (instret)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Present one instruction on the Memory-register inputs.
   task automatic drive(input logic [1:0] sel, input logic [4:0] rd, input logic [2:0] f3,
                        input logic [31:0] alu, input logic [31:0] dout2, input logic [31:0] pc4,
                        input logic [31:0] csr, input logic regw);
      mem_valid = 1'b1;
      mem_sel   = sel;
      mem_ir    = {17'd0, f3, rd, 7'b0000011};
      mem_alu   = alu;
      mem_dout2 = dout2;
      mem_pc4   = pc4;
      mem_csr_set(csr);
      mem_regw  = regw;
   endtask

   task automatic mem_csr_set(input logic [31:0] csr);
      csr_rd = csr;
   endtask

   // Wait (bounded) for acceptance; record the expected register-file write if it will write.
   task automatic accept(input logic track, input logic [31:0] exp_wd);
      int n;
      n = 0;
      @(negedge clk);
      while (!in_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("in_ready_accept", {63'd0, in_ready}, 64'd1);
      if (in_ready && track && mem_regw && (mem_ir[11:7] != 5'd0)) begin
         sb.push_back({mem_ir[11:7], exp_wd});
      end
      @(posedge clk);
      #1;
      mem_valid = 1'b0;
   endtask

   task automatic send(input logic [1:0] sel, input logic [4:0] rd, input logic [2:0] f3,
                       input logic [31:0] alu, input logic [31:0] dout2, input logic [31:0] pc4,
                       input logic [31:0] csr, input logic regw, input logic [31:0] exp_wd,
                       input logic track);
      drive(sel, rd, f3, alu, dout2, pc4, csr, regw);
      accept(track, exp_wd);
   endtask

   // Scoreboard: every write consumed by the register file must match the oldest expectation.
   always @(negedge clk) begin
      logic [36:0] item;
      if (rst_n && rf_we && rf_ready) begin
         if (sb.size() == 0) begin
            compared++;
            mismatched++;
            $error("FAIL unexpected_write: observed wa=%0d wd=%0h expected no write", rf_wa, rf_wd);
         end else begin
            item = sb.pop_front();
            check("wb_wa", {59'd0, rf_wa}, {59'd0, item[36:32]});
            check("wb_wd", {32'd0, rf_wd}, {32'd0, item[31:0]});
         end
      end
   end

   initial begin
      rst_n     = 1'b0;
      mem_valid = 1'b0;
      mem_ir    = '0;
      mem_pc4   = '0;
      mem_alu   = '0;
      mem_dout2 = '0;
      mem_sel   = 2'd0;
      mem_regw  = 1'b0;
      csr_rd    = '0;
      rf_ready  = 1'b1;
      fwd_addr  = 5'd0;

      // Reset state
      #3;
      check("rst_ready", {63'd0, in_ready}, 64'd1);
      check("rst_we", {63'd0, rf_we}, 64'd0);
      check("rst_wa", {59'd0, rf_wa}, 64'd0);
      check("rst_wd", {32'd0, rf_wd}, 64'd0);
      check("rst_hit", {63'd0, fwd_hit}, 64'd0);
      check("rst_fdata", {32'd0, fwd_data}, 64'd0);
      check("rst_instret", instret, 64'd0);
      #9 rst_n = 1'b1;
      @(posedge clk);
      #1;

      // ALU write, one-cycle latency to the write port
      send(2'd3, 5'd5, 3'b000, 32'h1234, 32'h0, 32'h0, 32'h0, 1'b1, 32'h1234, 1'b1);
      check("alu_we", {63'd0, rf_we}, 64'd1);
      check("alu_wa", {59'd0, rf_wa}, 64'd5);
      check("alu_wd", {32'd0, rf_wd}, 64'h1234);
      repeat (2) @(posedge clk);
      #1;
      check("alu_instret", instret, 64'd1);

      // Loads and other write sources
      send(2'd2, 5'd10, 3'b000, 32'h102, 32'h80FF7F01, 32'h0, 32'h0, 1'b1, 32'hFFFFFFFF, 1'b1);
      send(2'd2, 5'd11, 3'b100, 32'h102, 32'h80FF7F01, 32'h0, 32'h0, 1'b1, 32'h000000FF, 1'b1);
      send(2'd2, 5'd12, 3'b001, 32'h102, 32'h80FF7F01, 32'h0, 32'h0, 1'b1, 32'hFFFF80FF, 1'b1);
      send(2'd2, 5'd13, 3'b101, 32'h102, 32'h80FF7F01, 32'h0, 32'h0, 1'b1, 32'h000080FF, 1'b1);
      send(2'd2, 5'd14, 3'b010, 32'h101, 32'h80FF7F01, 32'h0, 32'h0, 1'b1, 32'h80FF7F01, 1'b1);
      send(2'd2, 5'd15, 3'b001, 32'h101, 32'h80FF7F01, 32'h0, 32'h0, 1'b1, 32'h00007F01, 1'b1);
      send(2'd2, 5'd16, 3'b000, 32'h103, 32'h80FF7F01, 32'h0, 32'h0, 1'b1, 32'hFFFFFF80, 1'b1);
      send(2'd2, 5'd17, 3'b011, 32'h102, 32'h80FF7F01, 32'h0, 32'h0, 1'b1, 32'h80FF7F01, 1'b1);
      send(2'd2, 5'd18, 3'b100, 32'h100, 32'h80FF7F01, 32'h0, 32'h0, 1'b1, 32'h00000001, 1'b1);
      send(2'd2, 5'd19, 3'b101, 32'h100, 32'h80FF7F01, 32'h0, 32'h0, 1'b1, 32'h00007F01, 1'b1);
      send(2'd0, 5'd1, 3'b000, 32'h55, 32'h0, 32'h400, 32'h0, 1'b1, 32'h400, 1'b1);
      send(2'd1, 5'd2, 3'b000, 32'h55, 32'h0, 32'h0, 32'hCAFE, 1'b1, 32'hCAFE, 1'b1);
      repeat (3) @(posedge clk);
      #1;
      check("loads_instret", instret, 64'd13);

      // Backpressure and forwarding with two buffered writes to x7
      rf_ready = 1'b0;
      send(2'd3, 5'd7, 3'b000, 32'hA, 32'h0, 32'h0, 32'h0, 1'b1, 32'hA, 1'b1);
      send(2'd3, 5'd7, 3'b000, 32'hB, 32'h0, 32'h0, 32'h0, 1'b1, 32'hB, 1'b1);
      check("bp_full_ready", {63'd0, in_ready}, 64'd0);
      fwd_addr = 5'd7;
      #1;
      check("fwd_hit7", {63'd0, fwd_hit}, 64'd1);
      check("fwd_data7", {32'd0, fwd_data}, 64'hB);
      fwd_addr = 5'd0;
      #1;
      check("fwd_hit0", {63'd0, fwd_hit}, 64'd0);
      check("fwd_data0", {32'd0, fwd_data}, 64'd0);
      drive(2'd3, 5'd8, 3'b000, 32'hC, 32'h0, 32'h0, 32'h0, 1'b1);
      repeat (2) @(posedge clk);
      #1;
      check("bp_held_ready", {63'd0, in_ready}, 64'd0);
      check("bp_held_instret", instret, 64'd13);
      rf_ready = 1'b1;
      accept(1'b1, 32'hC);
      repeat (3) @(posedge clk);
      #1;
      check("bp_instret", instret, 64'd16);
      check("bp_ready_back", {63'd0, in_ready}, 64'd1);

      // rd=0 and regWrite=0 entries retire without writing or forwarding
      rf_ready = 1'b0;
      send(2'd3, 5'd0, 3'b000, 32'h55, 32'h0, 32'h0, 32'h0, 1'b1, 32'h55, 1'b1);
      check("rd0_we", {63'd0, rf_we}, 64'd0);
      send(2'd3, 5'd9, 3'b000, 32'h99, 32'h0, 32'h0, 32'h0, 1'b0, 32'h99, 1'b1);
      fwd_addr = 5'd9;
      #1;
      check("nowr_hit", {63'd0, fwd_hit}, 64'd0);
      fwd_addr = 5'd0;
      rf_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("nowr_instret", instret, 64'd18);

      // Reset with a full buffer discards both entries
      rf_ready = 1'b0;
      send(2'd3, 5'd11, 3'b000, 32'h11, 32'h0, 32'h0, 32'h0, 1'b1, 32'h11, 1'b0);
      send(2'd3, 5'd12, 3'b000, 32'h12, 32'h0, 32'h0, 32'h0, 1'b1, 32'h12, 1'b0);
      check("pre_rst_we", {63'd0, rf_we}, 64'd1);
      #2 rst_n = 1'b0;
      #1;
      check("midrst_we", {63'd0, rf_we}, 64'd0);
      check("midrst_ready", {63'd0, in_ready}, 64'd1);
      check("midrst_instret", instret, 64'd0);
      #3 rst_n = 1'b1;
      rf_ready = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      check("postrst_instret", instret, 64'd0);
      check("postrst_we", {63'd0, rf_we}, 64'd0);

      check("sb_drained", 64'(sb.size()), 64'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
